wb_cmd_fifo_slave: RTL and testbench
====================================

# wb_cmd_fifo_slave

Wishbone pipelined slave that terminates the UART bridge's write bursts. Data words written anywhere in a 16-word address window (base 0x4020) are queued in an internal FIFO. The FIFO is drained by the downstream DSP controller through a valid/ready stream. The block also flags each completed bus burst as a command frame and exposes FIFO status through bus reads.

## Interface
Parameters:
- WISHBONE_DATAWIDTH, 16, bus and FIFO word width
- WISHBONE_ADDRESSWIDTH, 16, bus address width
- BASE_ADDR, 'h4020, window base; must be 16-word aligned
- FIFO_ADDR_BITS, 4, FIFO depth = 2**FIFO_ADDR_BITS (16)

Ports:
- CLK_I  in  1  single clock; all logic on rising edge
- RST_I  in  1  synchronous, active-high reset
- CYC_I  in  1  bus cycle in progress
- STB_I  in  1  transfer strobe
- WE_I  in  1  1 = write, 0 = read
- ADR_I  in  WISHBONE_ADDRESSWIDTH  word address
- DAT_I  in  WISHBONE_DATAWIDTH  write data
- DAT_O  out  WISHBONE_DATAWIDTH  read data, valid with ACK_O
- ACK_O  out  1  one pulse per accepted transfer
- STALL_O  out  1  transfer not accepted this cycle
- cmd_data  out  WISHBONE_DATAWIDTH  FIFO head word
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  consumer pops head when cmd_valid & cmd_ready
- cmd_count  out  FIFO_ADDR_BITS+1  words held, 0..16
- frame_done  out  1  one-cycle pulse: burst containing at least one write has ended

## Operation
- hit = (ADR_I[15:4] == BASE_ADDR[15:4]); offset = ADR_I[3:0].
- STALL_O = CYC_I & STB_I & WE_I & hit & full. It is combinational from the registered count. Reads never stall.
- Accept = CYC_I & STB_I & hit & ~STALL_O. Miss: no ACK_O, no state change, DAT_O = 0.
- Accepted write: push DAT_I at wr_ptr, wr_ptr+1 (wraps modulo 16), set burst_wr flag.
- Accepted read, offset 0: DAT_O = zero-extended cmd_count.
- Accepted read, offset ≠ 0: DAT_O = head word (peek, no pop), 0 if empty.
- Pop: cmd_valid & cmd_ready → rd_ptr+1 (wraps). cmd_ready while empty is ignored.
- Count: push and pop in the same cycle leave count unchanged. Push only → +1. Pop only → −1.
- Full is count == 16. When full and a pop occurs, the stalled push is not taken that cycle; it is accepted next cycle (the master holds STB_I).
- Frame tracking: cyc_d registers CYC_I. On CYC_I falling (cyc_d & ~CYC_I) with burst_wr set, pulse frame_done and clear burst_wr. Read-only bursts produce no pulse.
- Reset (also mid-burst) clears pointers, count, burst_wr, cyc_d, ACK_O, DAT_O. No frame_done pulse follows a reset, even if CYC_I drops afterwards. FIFO storage RAM is not reset.

## Timing
- Reset values: ACK_O=0, DAT_O=0, frame_done=0, cmd_valid=0, cmd_count=0, STALL_O=0 unless the full condition holds (impossible directly after reset).
- ACK_O and DAT_O are registered, exactly 1 cycle after accept. Back-to-back accepts give a continuous ACK_O train.
- ACK_O is not gated by CYC_I: an accept in the last cycle of a burst still ACKs one cycle later.
- cmd_valid and cmd_count update 1 cycle after a push or pop. cmd_data is combinational from storage at rd_ptr.
- Write to cmd_valid latency: 1 cycle (push at edge N, cmd_valid high after edge N).
- frame_done is asserted in the cycle after the edge that samples CYC_I low.
- Throughput: 1 write per cycle while not full; 1 pop per cycle.

## Structure
- Shared package holds: WB_CMD_BASE ('h4020), WB_WINDOW_BITS (4), STATUS_OFFSET (0), default widths.
- The UART bridge imports the same base constant so the window and the bridge's 0x4020+n addressing cannot diverge.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) holds the FIFO. The top holds decode, ACK pipeline, read mux and frame tracking.

## Test plan
- Reset, then write 0x0011, 0x0022, 0x0033 to 0x4020..0x4022 back-to-back, then drop CYC_I. Required: ACK_O on 3 consecutive cycles each one cycle after its strobe, cmd_count=3, one frame_done pulse, and cmd_data=0x0011 with cmd_ready low.
- 17 writes with cmd_ready=0. Required: 16 ACKs, STALL_O high on write 17, cmd_count=16. Pulse cmd_ready one cycle: write 17 is accepted the cycle after, ACK follows, count returns to 16, pop order 1..17 preserved.
- Read 0x4020 holding 5 words → DAT_O=0x0005. Read 0x4027 → DAT_O=head word, count still 5. Read-only burst end → no frame_done.
- Write to 0x4030 (miss). Required: no ACK_O, STALL_O=0, cmd_count unchanged.
- Simultaneous push and pop at count=4 → count stays 4. Pointers wrap after 20 push/pop pairs and data order is correct.
- Assert RST_I mid-burst after 2 writes, then drop CYC_I. Required: count=0, cmd_valid=0, no frame_done, and ACK_O=0 the cycle after reset.

Source files
------------

// File: rtl/wb_cmd_fifo_slave_pkg.sv
// Shared constants for the UART-bridge command window at 0x4020.
// The bridge imports WB_CMD_BASE too, so its 0x4020+n addressing tracks this window.
package wb_cmd_fifo_slave_pkg;

   localparam int          WB_DATA_W_DEF      = 16;
   localparam int          WB_ADDR_W_DEF      = 16;
   localparam int          FIFO_ADDR_BITS_DEF = 4;

   localparam logic [15:0] WB_CMD_BASE        = 16'h4020;
   localparam int          WB_WINDOW_BITS     = 4;
   localparam logic [3:0]  STATUS_OFFSET      = 4'd0;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_WRITE,
      ACC_READ_STATUS,
      ACC_READ_PEEK
   } acc_kind_e;

endpackage

// File: rtl/wb_cmd_fifo_slave_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is deliberately left unreset.
module wb_cmd_fifo_slave_sync_fifo #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [WIDTH-1:0]     data_i,
   input  logic                 pop_i,
   output logic [WIDTH-1:0]     data_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [ADDR_BITS:0]   count_o
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic                 do_push;
   logic                 do_pop;

   assign full_o  = (count_q == (ADDR_BITS+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/wb_cmd_fifo_slave.sv
// Wishbone pipelined slave queuing window writes into a command FIFO drained by a
// valid/ready stream; reads return FIFO status or peek the head word.
module wb_cmd_fifo_slave
   import wb_cmd_fifo_slave_pkg::*;
#(
   parameter int                               WISHBONE_DATAWIDTH    = WB_DATA_W_DEF,
   parameter int                               WISHBONE_ADDRESSWIDTH = WB_ADDR_W_DEF,
   parameter logic [WISHBONE_ADDRESSWIDTH-1:0] BASE_ADDR             = WISHBONE_ADDRESSWIDTH'(WB_CMD_BASE),
   parameter int                               FIFO_ADDR_BITS        = FIFO_ADDR_BITS_DEF
) (
   input  logic                             CLK_I,
   input  logic                             RST_I,
   input  logic                             CYC_I,
   input  logic                             STB_I,
   input  logic                             WE_I,
   input  logic [WISHBONE_ADDRESSWIDTH-1:0] ADR_I,
   input  logic [WISHBONE_DATAWIDTH-1:0]    DAT_I,
   output logic [WISHBONE_DATAWIDTH-1:0]    DAT_O,
   output logic                             ACK_O,
   output logic                             STALL_O,
   output logic [WISHBONE_DATAWIDTH-1:0]    cmd_data,
   output logic                             cmd_valid,
   input  logic                             cmd_ready,
   output logic [FIFO_ADDR_BITS:0]          cmd_count,
   output logic                             frame_done
);

   logic                          hit;
   logic [WB_WINDOW_BITS-1:0]     offset;
   logic                          stall;
   logic                          accept;
   logic                          push;
   logic                          pop;
   acc_kind_e                     kind;

   logic                          fifo_full;
   logic                          fifo_empty;
   logic [FIFO_ADDR_BITS:0]       fifo_count;
   logic [WISHBONE_DATAWIDTH-1:0] fifo_head;

   logic                          ack_q, ack_d;
   logic [WISHBONE_DATAWIDTH-1:0] dat_q, dat_d;
   logic                          cyc_q, cyc_d;
   logic                          burst_wr_q, burst_wr_d;
   logic                          frame_q, frame_d;

   assign hit    = (ADR_I[WISHBONE_ADDRESSWIDTH-1:WB_WINDOW_BITS] ==
                    BASE_ADDR[WISHBONE_ADDRESSWIDTH-1:WB_WINDOW_BITS]);
   assign offset = ADR_I[WB_WINDOW_BITS-1:0];

   // Full comes from the registered count, so a pop in the same cycle does not unstall.
   assign stall  = CYC_I & STB_I & WE_I & hit & fifo_full;
   assign accept = CYC_I & STB_I & hit & ~stall;
   assign push   = accept & WE_I;
   assign pop    = ~fifo_empty & cmd_ready;

   always_comb begin
      kind = ACC_NONE;
      if (accept) begin
         if (WE_I) begin
            kind = ACC_WRITE;
         end else if (offset == STATUS_OFFSET) begin
            kind = ACC_READ_STATUS;
         end else begin
            kind = ACC_READ_PEEK;
         end
      end
   end

   always_comb begin
      ack_d = accept;
      dat_d = '0;
      case (kind)
         ACC_READ_STATUS: dat_d = WISHBONE_DATAWIDTH'(fifo_count);
         ACC_READ_PEEK:   dat_d = fifo_empty ? '0 : fifo_head;
         default:         dat_d = '0;
      endcase
   end

   // A burst ends on the falling edge of CYC_I; only bursts that pushed report a frame.
   always_comb begin
      cyc_d      = CYC_I;
      frame_d    = 1'b0;
      burst_wr_d = burst_wr_q;
      if (push) begin
         burst_wr_d = 1'b1;
      end else if (cyc_q & ~CYC_I & burst_wr_q) begin
         frame_d    = 1'b1;
         burst_wr_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         cyc_q      <= 1'b0;
         burst_wr_q <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         cyc_q      <= cyc_d;
         burst_wr_q <= burst_wr_d;
         frame_q    <= frame_d;
      end
   end

   wb_cmd_fifo_slave_sync_fifo #(
      .WIDTH     (WISHBONE_DATAWIDTH),
      .ADDR_BITS (FIFO_ADDR_BITS)
   ) u_fifo (
      .clk_i   (CLK_I),
      .rst_i   (RST_I),
      .push_i  (push),
      .data_i  (DAT_I),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ACK_O      = ack_q;
   assign DAT_O      = dat_q;
   assign STALL_O    = stall;
   assign cmd_data   = fifo_head;
   assign cmd_valid  = ~fifo_empty;
   assign cmd_count  = fifo_count;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_wb_cmd_fifo_slave.sv
// Bench for wb_cmd_fifo_slave: directed vector table, hand sequences for full/wrap/reset,
// and random traffic checked against a queue-based reference model.
module tb_wb_cmd_fifo_slave;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        CYC_I, STB_I, WE_I;
   logic [15:0] ADR_I, DAT_I, DAT_O;
   logic        ACK_O, STALL_O;
   logic [15:0] cmd_data;
   logic        cmd_valid, cmd_ready;
   logic [4:0]  cmd_count;
   logic        frame_done;

   always #5 CLK_I = ~CLK_I;

   wb_cmd_fifo_slave dut (
      .CLK_I      (CLK_I),
      .RST_I      (RST_I),
      .CYC_I      (CYC_I),
      .STB_I      (STB_I),
      .WE_I       (WE_I),
      .ADR_I      (ADR_I),
      .DAT_I      (DAT_I),
      .DAT_O      (DAT_O),
      .ACK_O      (ACK_O),
      .STALL_O    (STALL_O),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_count  (cmd_count),
      .frame_done (frame_done)
   );

   typedef struct {
      bit          cyc, stb, we;
      logic [15:0] adr, dat;
      bit          rdy;
      bit          e_stall, e_ack;
      logic [15:0] e_dat;
      int          e_count;
      bit          e_frame;
   } vec_t;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: FIFO contents as a queue, plus burst bookkeeping
   logic [15:0] mq[$];
   bit          m_burst;
   bit          m_cyc;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic vec_t mk(bit cyc, bit stb, bit we, logic [15:0] adr, logic [15:0] dat, bit rdy);
      vec_t v;
      v = '{cyc, stb, we, adr, dat, rdy, 1'b0, 1'b0, 16'h0, 0, 1'b0};
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_burst = 1'b0;
      m_cyc   = 1'b0;
   endtask

   // One bus cycle: drive, check combinational outputs, clock, check registered outputs.
   task automatic cycle(input vec_t v, output bit st);
      bit          hit, stall, acc, push, pop, efr;
      logic [15:0] edat;
      CYC_I = v.cyc; STB_I = v.stb; WE_I = v.we;
      ADR_I = v.adr; DAT_I = v.dat; cmd_ready = v.rdy;
      #1;
      st    = STALL_O;
      hit   = (v.adr[15:4] == 12'h402);
      stall = v.cyc && v.stb && v.we && hit && (mq.size() == 16);
      check("stall", STALL_O, stall);
      check("cmd_valid", cmd_valid, mq.size() != 0);
      check("cmd_count", cmd_count, mq.size());
      if (mq.size() != 0) check("cmd_data", cmd_data, mq[0]);
      acc  = v.cyc && v.stb && hit && !stall;
      push = acc && v.we;
      pop  = (mq.size() != 0) && v.rdy;
      edat = 16'h0;
      if (acc && !v.we) begin
         if (v.adr[3:0] == 4'h0) edat = 16'(mq.size());
         else if (mq.size() != 0) edat = mq[0];
      end
      efr = m_cyc && !v.cyc && m_burst;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(v.dat);
      if (push) m_burst = 1'b1;
      if (efr)  m_burst = 1'b0;
      m_cyc = v.cyc;
      @(posedge CLK_I); #1;
      check("ack", ACK_O, acc);
      check("dat_o", DAT_O, edat);
      check("frame_done", frame_done, efr);
   endtask

   task automatic do_reset();
      RST_I = 1'b1;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      ADR_I = 16'h0; DAT_I = 16'h0; cmd_ready = 1'b0;
      repeat (2) @(posedge CLK_I);
      #1;
      RST_I = 1'b0;
      model_reset();
   endtask

   vec_t tbl[13];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit st;
      vec_t v;

      tbl[0]  = '{1,1,1,16'h4020,16'h0011,0, 0,1,16'h0000,1,0};
      tbl[1]  = '{1,1,1,16'h4021,16'h0022,0, 0,1,16'h0000,2,0};
      tbl[2]  = '{1,1,1,16'h4022,16'h0033,0, 0,1,16'h0000,3,0};
      tbl[3]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,3,1};
      tbl[4]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,3,0};
      tbl[5]  = '{1,1,1,16'h4030,16'hbeef,0, 0,0,16'h0000,3,0};
      tbl[6]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,3,0};
      tbl[7]  = '{1,1,1,16'h4023,16'h0044,0, 0,1,16'h0000,4,0};
      tbl[8]  = '{1,1,1,16'h4024,16'h0055,0, 0,1,16'h0000,5,0};
      tbl[9]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,5,1};
      tbl[10] = '{1,1,0,16'h4020,16'h0000,0, 0,1,16'h0005,5,0};
      tbl[11] = '{1,1,0,16'h4027,16'h0000,0, 0,1,16'h0011,5,0};
      tbl[12] = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,5,0};

      // reset state
      do_reset();
      check("rst_ack", ACK_O, 1'b0);
      check("rst_dat", DAT_O, 16'h0);
      check("rst_frame", frame_done, 1'b0);
      check("rst_valid", cmd_valid, 1'b0);
      check("rst_count", cmd_count, 5'd0);
      check("rst_stall", STALL_O, 1'b0);

      // directed table
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i], st);
         check($sformatf("tbl%0d_stall", i), st, tbl[i].e_stall);
         check($sformatf("tbl%0d_ack", i), ACK_O, tbl[i].e_ack);
         check($sformatf("tbl%0d_dat", i), DAT_O, tbl[i].e_dat);
         check($sformatf("tbl%0d_count", i), cmd_count, tbl[i].e_count);
         check($sformatf("tbl%0d_frame", i), frame_done, tbl[i].e_frame);
      end
      check("tbl_head", cmd_data, 16'h0011);

      // drain, then fill to 16 and present a 17th write
      for (int i = 0; i < 6; i++) cycle(mk(0,0,0,16'h0,16'h0,1), st);
      check("drained", cmd_count, 5'd0);
      for (int i = 1; i <= 16; i++) cycle(mk(1,1,1,16'h4020 | 16'(i % 16),16'(i),0), st);
      check("full_count", cmd_count, 5'd16);
      cycle(mk(1,1,1,16'h4021,16'd17,0), st);
      check("w17_stall", st, 1'b1);
      check("w17_noack", ACK_O, 1'b0);
      cycle(mk(1,1,1,16'h4021,16'd17,1), st);
      check("w17_stall_on_pop", st, 1'b1);
      check("w17_noack_on_pop", ACK_O, 1'b0);
      check("count_after_pop", cmd_count, 5'd15);
      cycle(mk(1,1,1,16'h4021,16'd17,0), st);
      check("w17_accept", st, 1'b0);
      check("w17_ack", ACK_O, 1'b1);
      check("count_back_16", cmd_count, 5'd16);
      cycle(mk(0,0,0,16'h0,16'h0,0), st);
      check("full_frame", frame_done, 1'b1);
      for (int k = 2; k <= 17; k++) begin
         check("pop_order", cmd_data, 16'(k));
         cycle(mk(0,0,0,16'h0,16'h0,1), st);
      end
      check("empty_after_drain", cmd_valid, 1'b0);

      // simultaneous push/pop at count 4, wrapping pointers
      for (int i = 0; i < 4; i++) cycle(mk(1,1,1,16'h4020,16'(100 + i),0), st);
      for (int i = 0; i < 20; i++) begin
         cycle(mk(1,1,1,16'h402f,16'(200 + i),1), st);
         check("pp_count", cmd_count, 5'd4);
      end
      cycle(mk(0,0,0,16'h0,16'h0,0), st);
      for (int k = 216; k < 220; k++) begin
         check("wrap_order", cmd_data, 16'(k));
         cycle(mk(0,0,0,16'h0,16'h0,1), st);
      end

      // reset in the middle of a write burst
      cycle(mk(1,1,1,16'h4020,16'haaaa,0), st);
      cycle(mk(1,1,1,16'h4021,16'hbbbb,0), st);
      RST_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 16'h4022; DAT_I = 16'hcccc;
      @(posedge CLK_I); #1;
      check("rst_mid_ack", ACK_O, 1'b0);
      check("rst_mid_count", cmd_count, 5'd0);
      check("rst_mid_valid", cmd_valid, 1'b0);
      RST_I = 1'b0;
      model_reset();
      cycle(mk(0,0,0,16'h0,16'h0,0), st);
      check("rst_mid_noframe", frame_done, 1'b0);
      check("rst_mid_count2", cmd_count, 5'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         logic [15:0] a;
         r = int'($urandom_range(0, 9));
         if (r < 8)       a = 16'h4020 | 16'($urandom_range(0, 15));
         else if (r == 8) a = 16'h4030 | 16'($urandom_range(0, 15));
         else             a = 16'h4010 | 16'($urandom_range(0, 15));
         v = mk($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
                $urandom_range(0, 99) < 70, a, 16'($urandom), $urandom_range(0, 99) < 30);
         cycle(v, st);
      end
      cycle(mk(0,0,0,16'h0,16'h0,0), st);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
